// File: rtl/arb_mux_rtl.sv
// Registered N-input round-robin multiplexer with val/rdy handshakes on both sides.
// Define ARB_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module arb_mux_rtl #(
    parameter int p_nbits = 32,
    parameter int p_nreqs = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [p_nreqs-1:0]             in_val,
    output logic [p_nreqs-1:0]             in_rdy,
    input  logic [p_nreqs*p_nbits-1:0]     in_data,
    input  logic [p_nreqs-1:0]             in_last,
    output logic                           out_val,
    input  logic                           out_rdy,
    output logic [p_nbits-1:0]             out_data,
    output logic [$clog2(p_nreqs)-1:0]     out_sel
);

    localparam int SW = $clog2(p_nreqs);
    localparam logic [SW-1:0] LAST_IDX = SW'(p_nreqs - 1);

    // Arbitration states, encoded directly in lock_val.
    localparam logic [0:0] ST_IDLE_RR = 1'b0;
    localparam logic [0:0] ST_LOCKED  = 1'b1;

    logic [SW-1:0]      ptr;
    logic [SW-1:0]      rr_gnt;
    logic [SW-1:0]      gnt;
    logic [SW-1:0]      next_ptr;
    logic               gnt_val;
    logic               can_acc;
    logic               xfer;
    logic               adv;
    logic [p_nbits-1:0] chan_data [p_nreqs];

    // First valid channel at or after start, wrapping by explicit compare so
    // that non-power-of-two channel counts never produce an out-of-range index.
    function automatic logic [SW-1:0] rr_pick(input logic [p_nreqs-1:0] val,
                                              input logic [SW-1:0]     start);
        logic [SW-1:0] idx;
        logic [SW-1:0] pick;
        logic          found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < p_nreqs; k++) begin
            if (!found && val[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < p_nreqs; i++) begin
            chan_data[i] = in_data[i*p_nbits +: p_nbits];
        end
    end

    assign can_acc = !out_val | out_rdy;
    assign rr_gnt  = rr_pick(in_val, ptr);

`ifdef ARB_MUX_LOCK_EN
    logic [0:0]    lock_val;
    logic [SW-1:0] lock_idx;

    always_comb begin
        gnt     = rr_gnt;
        gnt_val = |in_val;
        if (lock_val == ST_LOCKED) begin
            gnt     = lock_idx;
            gnt_val = in_val[lock_idx];
        end
    end

    // The pointer only moves once a packet is complete.
    assign adv = xfer & in_last[gnt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_val <= ST_IDLE_RR;
            lock_idx <= '0;
        end else if (xfer) begin
            lock_val <= in_last[gnt] ? ST_IDLE_RR : ST_LOCKED;
            lock_idx <= gnt;
        end
    end
`else
    logic unused_last;

    always_comb begin
        gnt     = rr_gnt;
        gnt_val = |in_val;
    end

    assign adv         = xfer;
    assign unused_last = ^in_last;
`endif

    assign xfer     = can_acc & gnt_val;
    assign next_ptr = (gnt == LAST_IDX) ? '0 : gnt + 1'b1;

    // NOTE: in_rdy gets its all-zero default before the conditional bit set so no latch is inferred.
    always_comb begin
        in_rdy = '0;
        if (xfer) begin
            in_rdy[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_val  <= 1'b0;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
        end else begin
            if (xfer) begin
                out_val  <= 1'b1;
                out_data <= chan_data[gnt];
                out_sel  <= gnt;
            end else if (out_rdy) begin
                out_val  <= 1'b0;
            end
            if (adv) begin
                ptr <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_rtl.sv
// Directed bench for arb_mux_rtl: a 4-channel instance for reset, rotation,
// backpressure and packet behaviour, and a 3-channel instance for the wrap.
module tb_arb_mux_rtl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 4-channel, 32-bit instance
    logic [3:0]   a_in_val;
    logic [3:0]   a_in_rdy;
    logic [127:0] a_in_data;
    logic [3:0]   a_in_last;
    logic         a_out_val;
    logic         a_out_rdy;
    logic [31:0]  a_out_data;
    logic [1:0]   a_out_sel;

    // 3-channel, 16-bit instance
    logic [2:0]   b_in_val;
    logic [2:0]   b_in_rdy;
    logic [47:0]  b_in_data;
    logic [2:0]   b_in_last;
    logic         b_out_val;
    logic         b_out_rdy;
    logic [15:0]  b_out_data;
    logic [1:0]   b_out_sel;

    arb_mux_rtl #(.p_nbits(32), .p_nreqs(4)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .in_val   (a_in_val),
        .in_rdy   (a_in_rdy),
        .in_data  (a_in_data),
        .in_last  (a_in_last),
        .out_val  (a_out_val),
        .out_rdy  (a_out_rdy),
        .out_data (a_out_data),
        .out_sel  (a_out_sel)
    );

    arb_mux_rtl #(.p_nbits(16), .p_nreqs(3)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .in_val   (b_in_val),
        .in_rdy   (b_in_rdy),
        .in_data  (b_in_data),
        .in_last  (b_in_last),
        .out_val  (b_out_val),
        .out_rdy  (b_out_rdy),
        .out_data (b_out_data),
        .out_sel  (b_out_sel)
    );

    // Packet stimulus outcome: channel 1 sends B0,B1,B2 (last on B2), channel 0 holds A0.
`ifdef ARB_MUX_LOCK_EN
    localparam logic [1:0]  EXP_SEL [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
    localparam logic [31:0] EXP_DAT [4] = '{32'hB0, 32'hB1, 32'hB2, 32'hA0};
`else
    localparam logic [1:0]  EXP_SEL [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
    localparam logic [31:0] EXP_DAT [4] = '{32'hB0, 32'hA0, 32'hB1, 32'hA0};
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int ch, input logic [31:0] d);
        a_in_data[ch*32 +: 32] = d;
    endtask

    task automatic set_b(input int ch, input logic [15:0] d);
        b_in_data[ch*16 +: 16] = d;
    endtask

    initial begin
        int beat;
        logic [1:0]  exp_b_sel;
        logic [2:0]  exp_b_rdy;

        rst       = 1'b1;
        a_in_val  = '0;
        a_in_data = '0;
        a_in_last = '1;
        a_out_rdy = 1'b0;
        b_in_val  = '0;
        b_in_data = '0;
        b_in_last = '1;
        b_out_rdy = 1'b1;
        tick();
        tick();
        #2 rst = 1'b0;

        // Load 0xDEAD and hold it with out_rdy low.
        set_a(0, 32'hDEAD);
        a_in_val = 4'b0001;
        tick();
        check("load_val", 64'(a_out_val), 64'd1);
        check("load_data", 64'(a_out_data), 64'hDEAD);

        // Asynchronous reset in mid-cycle, then grant behaviour while held in reset.
        a_in_val = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_out_val", 64'(a_out_val), 64'd0);
        check("rst_out_data", 64'(a_out_data), 64'd0);
        check("rst_out_sel", 64'(a_out_sel), 64'd0);
        a_in_val = 4'b1111;
        #1;
        check("rst_ptr_all", 64'(a_in_rdy), 64'b0001);
        a_in_val = 4'b1010;
        #1;
        check("rst_rdy_1010", 64'(a_in_rdy), 64'b0010);
        #1 rst = 1'b0;
        #1;
        check("rel_rdy_1010", 64'(a_in_rdy), 64'b0010);

        // Round-robin rotation with every channel valid.
        for (int i = 0; i < 4; i++) set_a(i, 32'h10 + 32'(i));
        a_in_val  = 4'b1111;
        a_out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_val", 64'(a_out_val), 64'd1);
            check("rr_data", 64'(a_out_data), 64'h10 + 64'(i % 4));
            check("rr_sel", 64'(a_out_sel), 64'(i % 4));
        end
        tick();
        check("rr_data_6", 64'(a_out_data), 64'h11);
        check("rr_sel_6", 64'(a_out_sel), 64'd1);

        // Backpressure: hold 0x11 for three cycles.
        a_out_rdy = 1'b0;
        #1;
        check("bp_rdy_now", 64'(a_in_rdy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_val", 64'(a_out_val), 64'd1);
            check("bp_data", 64'(a_out_data), 64'h11);
            check("bp_sel", 64'(a_out_sel), 64'd1);
            check("bp_rdy", 64'(a_in_rdy), 64'd0);
        end
        a_out_rdy = 1'b1;
        #1;
        check("bp_release_rdy", 64'(a_in_rdy), 64'b0100);
        tick();
        check("bp_nobubble_val", 64'(a_out_val), 64'd1);
        check("bp_nobubble_data", 64'(a_out_data), 64'h12);
        check("bp_nobubble_sel", 64'(a_out_sel), 64'd2);

        // Drain with no input: out_val drops, data/sel hold.
        a_in_val = '0;
        tick();
        check("drain_val", 64'(a_out_val), 64'd0);
        check("drain_data", 64'(a_out_data), 64'h12);
        check("drain_sel", 64'(a_out_sel), 64'd2);

        // Bring ptr to 1 via a single beat on channel 0.
        a_in_val = 4'b0001;
        tick();
        check("pre_pkt_sel", 64'(a_out_sel), 64'd0);

        // Packet on channel 1 while channel 0 stays valid.
        set_a(0, 32'hA0);
        set_a(1, 32'hB0);
        a_in_last = 4'b1101;
        a_in_val  = 4'b0011;
        beat = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pkt_sel", 64'(a_out_sel), 64'(EXP_SEL[i]));
            check("pkt_data", 64'(a_out_data), 64'(EXP_DAT[i]));
            if (EXP_SEL[i] == 2'd1) begin
                beat++;
                set_a(1, 32'hB0 + 32'(beat));
                a_in_last[1] = (beat == 2);
                if (beat == 3) a_in_val[1] = 1'b0;
            end
        end

        // Reset in the middle of a channel 1 packet.
        set_a(1, 32'hB0);
        a_in_last[1] = 1'b0;
        a_in_val     = 4'b0011;
        tick();
        check("midpkt_sel", 64'(a_out_sel), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midpkt_rst_val", 64'(a_out_val), 64'd0);
        #1 rst = 1'b0;
        #1;
        check("midpkt_rdy", 64'(a_in_rdy), 64'b0001);
        tick();
        check("midpkt_first_sel", 64'(a_out_sel), 64'd0);
        check("midpkt_first_data", 64'(a_out_data), 64'hA0);
        a_in_val = '0;

        // Three-channel wrap: move ptr to 2, then only channels 2 and 0 valid.
        for (int i = 0; i < 3; i++) set_b(i, 16'h0C0 + 16'(i * 'h101));
        b_in_val = 3'b010;
        tick();
        check("b_setup_sel", 64'(b_out_sel), 64'd1);
        check("b_setup_data", 64'(b_out_data), 64'h1C1);
        b_in_val = 3'b101;
        #1;
        check("b_rdy_start", 64'(b_in_rdy), 64'b100);
        for (int i = 0; i < 4; i++) begin
            exp_b_sel = (i % 2 == 0) ? 2'd2 : 2'd0;
            exp_b_rdy = (i % 2 == 0) ? 3'b001 : 3'b100;
            tick();
            check("b_wrap_val", 64'(b_out_val), 64'd1);
            check("b_wrap_sel", 64'(b_out_sel), 64'(exp_b_sel));
            check("b_wrap_data", 64'(b_out_data), (exp_b_sel == 2'd2) ? 64'h2C2 : 64'h0C0);
            check("b_wrap_rdy", 64'(b_in_rdy), 64'(exp_b_rdy));
        end
        b_in_val = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arb_mux_rtl.md
# arb_mux_rtl

Parametrised, registered N-input multiplexer with round-robin arbitration and latency-insensitive val/rdy handshakes. It is the successor to the fixed 4-input combinational select mux. The select is generated internally from requester valids rather than driven externally, and the output is a single registered pipeline stage. It sits where several producers share one datapath, such as memory-request merging or writeback-port sharing in the processor.

## Interface
- p_nbits, 32, data width of each channel
- p_nreqs, 4, number of input channels; legal range 2..16
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_val  input  p_nreqs  per-channel valid; bit i belongs to channel i
- in_rdy  output  p_nreqs  per-channel ready; one-hot or zero
- in_data  input  p_nreqs*p_nbits  packed data; channel i is at [i*p_nbits +: p_nbits]
- in_last  input  p_nreqs  per-channel end-of-packet flag; used only with lock enabled
- out_val  output  1  output register holds a valid beat
- out_rdy  input  1  downstream accepts the beat
- out_data  output  p_nbits  registered data
- out_sel  output  $clog2(p_nreqs)  channel index of the beat in the output register

## Operation
- **State**
  - ptr: $clog2(p_nreqs) bits, the highest-priority channel.
  - Output register: out_val, out_data, out_sel.
  - lock_val/lock_idx: present only with the macro.
- **Accept condition:** can_acc = !out_val | out_rdy. The stage accepts a new beat in the same cycle the held beat drains, so throughput is 1 beat/cycle.
- **Grant (combinational)**
  - Scan channels starting at ptr and wrapping modulo p_nreqs.
  - gnt = the first i with in_val[i].
  - in_rdy[i] = can_acc & (i == gnt) & any(in_val).
  - in_rdy never depends on in_data.
- **Transfer:** a transfer occurs on channel i when in_val[i] & in_rdy[i]. On the next edge the stage loads:
  - out_data = channel i data
  - out_sel = i
  - out_val = 1
- **Pointer update:** after a transfer on i, ptr = (i+1) mod p_nreqs. The wrap uses explicit compare against p_nreqs-1, not power-of-two truncation, because p_nreqs need not be a power of two.
- **Drain:** if out_val & out_rdy and there is no transfer, out_val goes to 0. out_data and out_sel hold their last values.
- **Idle/stall:** with no valid input, or with can_acc=0, no transfer occurs and ptr is unchanged.
- Input valids must stay high, with data stable, until a transfer. The block does not check this.
- **Arbitration FSM (conceptually two states)**
  - IDLE_RR: grant by round robin.
  - LOCKED: grant only lock_idx. Exists only with the macro.

## Timing
- Latency is 1 cycle, input transfer to out_val.
- Throughput is 1 beat/cycle under continuous out_rdy.
- **Reset (asynchronous, immediate):**
  - out_val=0, out_data=0, out_sel=0
  - ptr=0
  - lock_val=0
  - in_rdy follows combinationally, so in_rdy=0x1 if in_val[0]=1.
- **Reset asserted mid-packet or with a beat held:** the beat is discarded and the lock is cleared. There is no partial state after deassertion.
- **Simultaneous drain and accept:** the new beat replaces the old one in the same edge. out_val stays 1.
- **All channels valid:** grants rotate 0,1,...,p_nreqs-1,0. Worst-case wait per channel is p_nreqs-1 transfers.
- **out_rdy low with out_val=1:** all in_rdy are 0, and out_data/out_sel are held stable.

## Configuration
- **Macro:** ARB_MUX_LOCK_EN. The in_last port exists in both builds.
- **Defined (packet lock):**
  - A transfer with in_last[i]=0 sets lock_val=1 and lock_idx=i.
  - While locked, only channel lock_idx may be granted, even if it drops valid. Other channels wait.
  - A transfer with in_last=1 clears the lock and advances ptr to i+1.
  - ptr does not advance on non-last beats.
- **Undefined:**
  - in_last is ignored, no lock state exists, and every beat is arbitrated independently.
  - ptr advances after every transfer.

## Test plan
- **Reset behaviour:** assert rst with out_val=1 holding 0xDEAD. Check that out_val=0, out_data=0 and ptr=0 immediately, without waiting for a clock. Release with in_val=0b1010, p_nreqs=4. Check grant=1 and in_rdy=0b0010.
- **Round-robin rotation:** p_nreqs=4, all in_val=1, data = 0x10+i, out_rdy=1. Check out_data sequence 0x10,0x11,0x12,0x13,0x10 on consecutive cycles, with out_sel 0,1,2,3,0.
- **Backpressure:** hold out_rdy=0 for 3 cycles with out_val=1 and out_data=0x11. Check in_rdy=0 and out_data stable for those 3 cycles. Raise out_rdy. Check that the next beat 0x12 loads the same edge the old one drains, with no bubble.
- **Non-power-of-two wrap:** p_nreqs=3, only channels 2 and 0 valid, ptr=2. Check grants 2,0,2,0, and that ptr never reaches 3.
- **Packet lock (with ARB_MUX_LOCK_EN):** channel 1 sends 3 beats with in_last=0,0,1 while channel 0 is continuously valid. Check three consecutive out_sel=1, then out_sel=0. Without the macro, the same stimulus must interleave 1,0,1,0 (ptr starts at 1).
- **Lock cleared by reset:** assert rst in the middle of the channel 1 packet. After release, check that channel 0 is granted first.
